// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART byte stream to instruction-memory image loader
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

  // State entered once the image body is complete (or len == 0).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_END = S_CHK;
`else
  localparam logic [2:0] S_END = S_DONE;
`endif

  logic [2:0]  state;
  logic [1:0]  bcnt;
  logic [23:0] word_q;
  logic [31:0] len_q;
  logic [31:0] wcnt;
  logic [31:0] word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // Lane 3 is never stored: the 4th byte is used directly from rx_data.
  assign word_full = {rx_data, word_q};

  assign busy = ((state == S_LEN) && (bcnt != 2'd0)) ||
                (state == S_DATA) || (state == S_CHK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LEN;
      bcnt       <= 2'd0;
      word_q     <= 24'd0;
      len_q      <= 32'd0;
      wcnt       <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      imem_we  <= 1'b0;
      // Status flags follow the state one edge later, so done rises as the
      // final write cycle ends.
      done     <= (state == S_DONE);
      error    <= (state == S_ERR);
      cpu_hold <= (state != S_DONE);

      if (rx_valid && ((state == S_LEN) || (state == S_DATA))) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    word_q[7:0]   <= rx_data;
          2'd1:    word_q[15:8]  <= rx_data;
          2'd2:    word_q[23:16] <= rx_data;
          default: ;
        endcase
      end

      if (rx_valid) begin
        case (state)
          S_LEN: begin
            if (bcnt == 2'd3) begin
              if (word_full == 32'd0) begin
                state <= S_END;
              end else if (word_full > MAX_LEN) begin
                state <= S_ERR;
              end else begin
                len_q <= word_full;
                wcnt  <= 32'd0;
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (bcnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= wcnt[ADDR_W-1:0];
              imem_wdata <= word_full;
              wcnt       <= wcnt + 32'd1;
              if (wcnt == len_q - 32'd1) begin
                state <= S_END;
              end
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            state <= (rx_data == csum) ? S_DONE : S_ERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized byte-stream bench for imem_loader against an image-level model
module tb_imem_loader;

  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 16384;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t        wq[$];
  int         done_cyc = -1;
  int         err_cyc  = -1;
  logic [7:0] stream[$];
  int         sc[$];
  int         n_vec = 0;
  int         n_err = 0;

  // Observe memory writes and first rise of the sticky flags.
  always @(negedge clk) begin
    if (imem_we) wq.push_back('{int'(imem_addr), imem_wdata, cyc});
    if (done && done_cyc < 0) done_cyc = cyc;
    if (error && err_cyc < 0) err_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    done_cyc = -1;
    err_cyc  = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic build(input logic [31:0] len);
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(len[8*i +: 8]);
    if (len <= 32'(MAX_WORDS))
      for (int i = 0; i < 4 * int'(len); i++) stream.push_back(8'($urandom));
  endtask

  task automatic add_junk(input int n);
    repeat (n) stream.push_back(8'($urandom));
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic add_chk(input bit good);
    logic [31:0] len;
    logic [7:0]  x;
    len = {stream[3], stream[2], stream[1], stream[0]};
    x   = 8'h00;
    if (len <= 32'(MAX_WORDS)) begin
      for (int i = 4; i < 4 + 4 * int'(len); i++) x ^= stream[i];
      stream.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
    end
  endtask
`endif

  task automatic send_stream(input int gmin, input int gmax);
    sc.delete();
    foreach (stream[i]) begin
      rx_data  = stream[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      sc.push_back(cyc);
      if (i == 0) check_eq("busy_hdr0", 64'(busy), 64'd1);
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
    end
  endtask

  // Image-level reference: header length, word list, checksum verdict, flag timing.
  task automatic check_image(input string nm);
    logic [31:0] len;
    logic [31:0] w;
    bit          over;
    bit          exp_ok;
    int          nw;
    int          last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  x;
`endif
    repeat (3) @(negedge clk);
    len  = {stream[3], stream[2], stream[1], stream[0]};
    over = (len > 32'(MAX_WORDS));
    nw   = over ? 0 : int'(len);
    if (over) begin
      last   = 3;
      exp_ok = 1'b0;
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int i = 4; i < 4 + 4 * nw; i++) x ^= stream[i];
      last   = 4 + 4 * nw;
      exp_ok = (stream[last] == x);
`else
      last   = 3 + 4 * nw;
      exp_ok = 1'b1;
`endif
    end
    check_eq({nm, "_nwr"}, 64'(wq.size()), 64'(nw));
    for (int k = 0; k < nw && k < wq.size(); k++) begin
      w = {stream[4*k+7], stream[4*k+6], stream[4*k+5], stream[4*k+4]};
      check_eq($sformatf("%s_addr%0d", nm, k), 64'(wq[k].addr), 64'(k));
      check_eq($sformatf("%s_data%0d", nm, k), 64'(wq[k].data), 64'(w));
      check_eq($sformatf("%s_wcyc%0d", nm, k), 64'(wq[k].c), 64'(sc[4*k+7]));
    end
    check_eq({nm, "_done"}, 64'(done), 64'(exp_ok));
    check_eq({nm, "_error"}, 64'(error), 64'(!exp_ok));
    check_eq({nm, "_hold"}, 64'(cpu_hold), 64'(!exp_ok));
    check_eq({nm, "_busy"}, 64'(busy), 64'd0);
    check_eq({nm, "_flagcyc"}, 64'(exp_ok ? done_cyc : err_cyc), 64'(sc[last] + 1));
  endtask

  task automatic check_reset_vals(input string nm);
    check_eq({nm, "_we"}, 64'(imem_we), 64'd0);
    check_eq({nm, "_addr"}, 64'(imem_addr), 64'd0);
    check_eq({nm, "_wdata"}, 64'(imem_wdata), 64'd0);
    check_eq({nm, "_hold"}, 64'(cpu_hold), 64'd1);
    check_eq({nm, "_busy"}, 64'(busy), 64'd0);
    check_eq({nm, "_done"}, 64'(done), 64'd0);
    check_eq({nm, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("rst0");
    reset = 1'b0;
    clear_mon();

    // Two-word image, back-to-back bytes
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(1'b1);
`endif
    add_junk(3);
    send_stream(0, 0);
    check_image("two_words");

    // Zero-length image
    apply_reset();
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    send_stream(0, 0);
    check_image("len0");

    // Oversize length, later bytes ignored
    apply_reset();
    stream = '{8'h01, 8'h40, 8'h00, 8'h00};
    add_junk(9);
    send_stream(0, 1);
    check_image("oversize");

    // Sparse bytes, single word
    apply_reset();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(1'b1);
`endif
    send_stream(3, 3);
    check_image("sparse");

    // Asynchronous reset in the middle of word 1 of a 3-word image
    apply_reset();
    stream = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
               8'hAA, 8'hBB};
    send_stream(0, 0);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    build(32'd3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(1'b1);
`endif
    send_stream(0, 1);
    check_image("after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
    apply_reset();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    send_stream(0, 0);
    check_image("chk_good");
    apply_reset();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    add_junk(4);
    send_stream(0, 0);
    check_image("chk_bad");
`endif

    // Randomized images, including an occasional oversize header
    for (int it = 0; it < 10; it++) begin
      apply_reset();
      if (it == 9) build(32'($urandom_range(200000, MAX_WORDS + 1)));
      else build(32'($urandom_range(6, 0)));
`ifdef IMEM_LOADER_CHECKSUM_EN
      add_chk(1'($urandom_range(1, 0)));
`endif
      add_junk($urandom_range(3, 0));
      send_stream(0, 2);
      check_image($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
